// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset-cause codes
// and a small elaboration-time helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StHold    = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_BTN  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Asynchronous-assert, synchronous-release reset synchroniser. The output stays high
// until SYNC_STAGES clock edges have elapsed with the input reset low.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domains in reset after a button, software or lock-loss
// event, then releases the channels one by one and records the cause.
module reset_sequencer import rst_seq_pkg::*; #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned HOLD_CYCLES    = 5,
  parameter int unsigned STAGGER_CYCLES = 2,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              SYS_CLK,
  input  logic              BTN_RST,
  input  logic              lock_i,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              ready_o,
  output logic [1:0]        cause_o
);

  localparam int unsigned CntW = $clog2(max_u(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam int unsigned IdxW = $clog2(NUM_CH + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [IdxW-1:0] LastCh   = IdxW'(NUM_CH - 1);

  logic sync_rst;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              ready_q, ready_d;
  logic [1:0]        cause_q, cause_d;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i(SYS_CLK),
    .rst_i(BTN_RST),
    .rst_o(sync_rst)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    cause_d = cause_q;

    unique case (state_q)
      StAssert: begin
        state_d = StHold;
        cnt_d   = '0;
        idx_d   = '0;
      end

      // Lock loss here only stalls the hold count; it is not a reset event.
      StHold: begin
        if (lock_i) begin
          if (cnt_q == HoldLast) begin
            rst_n_d[0] = 1'b1;
            idx_d      = IdxW'(1);
            cnt_d      = '0;
            if (NUM_CH == 1) begin
              state_d = StRun;
              ready_d = 1'b1;
            end else begin
              state_d = StRelease;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StRelease, StRun: begin
        if (!lock_i || sw_rst_req_i) begin
          rst_n_d = '0;
          ready_d = 1'b0;
          state_d = StAssert;
          cnt_d   = '0;
          idx_d   = '0;
          cause_d = !lock_i ? CAUSE_LOCK : CAUSE_SW;
        end else if (state_q == StRelease) begin
          if (cnt_q == StagLast) begin
            rst_n_d = rst_n_q | (NUM_CH'(1) << idx_q);
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            if (idx_q == LastCh) begin
              state_d = StRun;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StAssert;
    endcase
  end

  // Until the synchroniser drains, the FSM is held at its reset values.
  always_ff @(posedge SYS_CLK or posedge BTN_RST) begin
    if (BTN_RST) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      cause_q <= CAUSE_BTN;
    end else if (sync_rst) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      cause_q <= CAUSE_BTN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign ready_o = ready_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default-parameter instance checked edge by edge through an
// expectation queue, plus a single-channel / one-cycle-hold instance checked directly.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       btn;
  logic       lock0, sw0;
  logic [2:0] rst_n0;
  logic       ready0;
  logic [1:0] cause0;

  logic       lock1, sw1;
  logic [0:0] rst_n1;
  logic       ready1;
  logic [1:0] cause1;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;

  always #5 clk = ~clk;

  reset_sequencer u_dut0 (
    .SYS_CLK     (clk),
    .BTN_RST     (btn),
    .lock_i      (lock0),
    .sw_rst_req_i(sw0),
    .rst_n_o     (rst_n0),
    .ready_o     (ready0),
    .cause_o     (cause0)
  );

  reset_sequencer #(
    .NUM_CH        (1),
    .HOLD_CYCLES   (1),
    .STAGGER_CYCLES(2),
    .SYNC_STAGES   (2)
  ) u_dut1 (
    .SYS_CLK     (clk),
    .BTN_RST     (btn),
    .lock_i      (lock1),
    .sw_rst_req_i(sw1),
    .rst_n_o     (rst_n1),
    .ready_o     (ready1),
    .cause_o     (cause1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {rst_n[2:0], ready, cause} at edge e when channel 0 releases at edge rel0.
  function automatic logic [5:0] exp_seq(input int e, input int rel0, input logic [1:0] c);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      if (e >= rel0 + 2 * k) r[k] = 1'b1;
    end
    return {r, (r == 3'b111), c};
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      check("seq", 32'({rst_n0, ready0, cause0}), 32'(mon_exp));
    end
  end

  // Called just after a falling edge; returns at the following falling edge.
  task automatic drive_edge(input logic lk, input logic sr, input logic [5:0] exp);
    lock0 = lk;
    sw0   = sr;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic btn_pulse();
    #1 btn = 1'b1;
    #1;
    check("async0", 32'({rst_n0, ready0, cause0}), 32'h0);
    check("async1", 32'({rst_n1, ready1, cause1}), 32'h0);
    #2 btn = 1'b0;
  endtask

  initial begin
    btn   = 1'b1;
    lock0 = 1'b1;
    sw0   = 1'b0;
    lock1 = 1'b1;
    sw1   = 1'b0;
    #1;
    check("reset", 32'({rst_n0, ready0, cause0}), 32'h0);
    drive_edge(1'b1, 1'b0, 6'b0);
    drive_edge(1'b1, 1'b0, 6'b0);

    // Basic power-on sequence.
    btn = 1'b0;
    for (int e = 1; e <= 13; e++) drive_edge(1'b1, 1'b0, exp_seq(e, 8, 2'b00));

    // Lock loss during HOLD stalls the count by exactly its length.
    btn_pulse();
    for (int e = 1; e <= 16; e++) begin
      drive_edge((e >= 5 && e <= 8) ? 1'b0 : 1'b1, 1'b0, exp_seq(e, 12, 2'b00));
    end

    // Software reset from RUN.
    drive_edge(1'b1, 1'b1, {4'b0000, 2'b01});
    for (int e = 1; e <= 10; e++) drive_edge(1'b1, 1'b0, exp_seq(e, 6, 2'b01));

    // Simultaneous lock loss and software request in RELEASE: lock loss wins.
    drive_edge(1'b1, 1'b1, {4'b0000, 2'b01});
    for (int e = 1; e <= 6; e++) drive_edge(1'b1, 1'b0, exp_seq(e, 6, 2'b01));
    drive_edge(1'b0, 1'b1, {4'b0000, 2'b10});
    for (int e = 1; e <= 10; e++) drive_edge(1'b1, 1'b0, exp_seq(e, 6, 2'b10));

    // Button pulse between edges mid-RELEASE.
    drive_edge(1'b1, 1'b1, {4'b0000, 2'b01});
    for (int e = 1; e <= 7; e++) drive_edge(1'b1, 1'b0, exp_seq(e, 6, 2'b01));
    btn_pulse();
    for (int e = 1; e <= 12; e++) drive_edge(1'b1, 1'b0, exp_seq(e, 8, 2'b00));

    // Single channel, one-cycle hold; software request while in HOLD is ignored.
    btn_pulse();
    for (int e = 1; e <= 5; e++) begin
      sw1 = (e == 3 || e == 4) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      check("ch1", 32'({rst_n1, ready1, cause1}), (e >= 4) ? 32'hC : 32'h0);
      @(negedge clk);
    end
    sw1 = 1'b0;

    check("drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
